// File: rtl/mem_line_bridge.sv
// Cache-line bridge: each 128-bit core line read/write becomes one 8-beat x 16-bit host burst.
// Beats may arrive before, with, or after the command ack; completion waits for both.
module mem_line_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_request,
  input  logic         mem_rwn,
  input  logic [15:0]  mem_addr,
  input  logic [127:0] mem_write_data,
  output logic         mem_finish,
  output logic [127:0] mem_read_data,
  output logic         host_req,
  output logic         host_rwn,
  output logic         host_burst,
  output logic [31:0]  host_addr,
  input  logic         host_ack,
  output logic [1:0]   host_txm,
  output logic [15:0]  host_txd,
  input  logic         host_txd_ack,
  input  logic [15:0]  host_rxd,
  input  logic         host_rxd_vld
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, FIN} state_t;
  state_t state_reg, state_next;

  logic [2:0]   beat_reg, beat_next;
  logic         beats_done_reg, beats_done_next;
  logic         cmd_acked_reg, cmd_acked_next;
  logic [127:0] wbuf_reg, wbuf_next;
  logic [127:0] rbuf_reg;
  wire  [127:0] rbuf_next;
  logic [15:0]  wbuf_word [8];
  logic         rwn_next;
  logic [31:0]  addr_next;
  logic         host_req_next, mem_finish_next;
  logic [127:0] mem_read_data_next;
  logic [15:0]  host_txd_next;

  logic start, active, beat_evt, last_evt, acked_now, done_now;
  logic [3:0] unused_addr_lsbs;

  assign unused_addr_lsbs = mem_addr[3:0];
  assign host_burst = 1'b1;
  assign host_txm   = 2'b00;

  // host_rwn / host_addr double as the latched command for the whole transfer.
  assign start     = (state_reg == IDLE) && mem_request;
  assign active    = (state_reg == CMD) || (state_reg == DATA);
  assign beat_evt  = active && !beats_done_reg && (host_rwn ? host_rxd_vld : host_txd_ack);
  assign last_evt  = beat_evt && (beat_reg == 3'd7);
  assign acked_now = cmd_acked_reg || ((state_reg == CMD) && host_ack);
  assign done_now  = beats_done_reg || last_evt;

  assign beat_next       = start ? 3'd0 : (beat_evt ? beat_reg + 3'd1 : beat_reg);
  assign beats_done_next = !start && done_now;
  assign cmd_acked_next  = !start && acked_now;
  assign rwn_next        = start ? mem_rwn : host_rwn;
  assign addr_next       = start ? BASE_ADDR + {16'b0, mem_addr[15:4], 4'b0} : host_addr;
  assign wbuf_next       = start ? mem_write_data : wbuf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_beat
      assign rbuf_next[gi*16 +: 16] = (beat_evt && host_rwn && (beat_reg == 3'(gi)))
                                      ? host_rxd : rbuf_reg[gi*16 +: 16];
      assign wbuf_word[gi] = wbuf_next[gi*16 +: 16];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Same-cycle ack and last beat in CMD skip DATA entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_request) state_next = CMD;
      CMD:     if (host_ack) state_next = done_now ? FIN : DATA;
      DATA:    if (acked_now && done_now) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    host_req_next      = (state_next == CMD);
    mem_finish_next    = (state_next == FIN);
    mem_read_data_next = mem_read_data;
    if ((state_next == FIN) && host_rwn) mem_read_data_next = rbuf_next;
    host_txd_next      = wbuf_word[beat_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_reg       <= 3'd0;
      beats_done_reg <= 1'b0;
      cmd_acked_reg  <= 1'b0;
      wbuf_reg       <= '0;
      rbuf_reg       <= '0;
      host_rwn       <= 1'b1;
      host_addr      <= 32'h0;
      host_req       <= 1'b0;
      mem_finish     <= 1'b0;
      mem_read_data  <= '0;
      host_txd       <= 16'h0;
    end else begin
      beat_reg       <= beat_next;
      beats_done_reg <= beats_done_next;
      cmd_acked_reg  <= cmd_acked_next;
      wbuf_reg       <= wbuf_next;
      rbuf_reg       <= rbuf_next;
      host_rwn       <= rwn_next;
      host_addr      <= addr_next;
      host_req       <= host_req_next;
      mem_finish     <= mem_finish_next;
      mem_read_data  <= mem_read_data_next;
      host_txd       <= host_txd_next;
    end
  end
endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: stimulus pushes expectations, a negedge monitor pops and checks.
// A second instance with BASE_ADDR = 0 shares all inputs so both address offsets are covered.
module tb_mem_line_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_request, mem_rwn;
  logic [15:0]  mem_addr;
  logic [127:0] mem_write_data;
  logic         host_ack, host_txd_ack, host_rxd_vld;
  logic [15:0]  host_rxd;

  logic         mem_finish, host_req, host_rwn, host_burst;
  logic [127:0] mem_read_data;
  logic [31:0]  host_addr;
  logic [1:0]   host_txm;
  logic [15:0]  host_txd;

  logic         b0_mem_finish, b0_host_req, b0_host_rwn, b0_host_burst;
  logic [127:0] b0_mem_read_data;
  logic [31:0]  b0_host_addr;
  logic [1:0]   b0_host_txm;
  logic [15:0]  b0_host_txd;

  mem_line_bridge #(.BASE_ADDR(32'h8000_0000)) u_dut (
    .clk(clk), .rst(rst), .mem_request(mem_request), .mem_rwn(mem_rwn),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_finish(mem_finish),
    .mem_read_data(mem_read_data), .host_req(host_req), .host_rwn(host_rwn),
    .host_burst(host_burst), .host_addr(host_addr), .host_ack(host_ack),
    .host_txm(host_txm), .host_txd(host_txd), .host_txd_ack(host_txd_ack),
    .host_rxd(host_rxd), .host_rxd_vld(host_rxd_vld)
  );

  mem_line_bridge #(.BASE_ADDR(32'h0000_0000)) u_dut_b0 (
    .clk(clk), .rst(rst), .mem_request(mem_request), .mem_rwn(mem_rwn),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_finish(b0_mem_finish),
    .mem_read_data(b0_mem_read_data), .host_req(b0_host_req), .host_rwn(b0_host_rwn),
    .host_burst(b0_host_burst), .host_addr(b0_host_addr), .host_ack(host_ack),
    .host_txm(b0_host_txm), .host_txd(b0_host_txd), .host_txd_ack(host_txd_ack),
    .host_rxd(host_rxd), .host_rxd_vld(host_rxd_vld)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic rwn; logic [31:0] a_hi; logic [31:0] a_lo; } cmd_t;
  typedef struct { int cyc; logic [127:0] data; } fin_t;

  cmd_t        cmd_q[$];
  fin_t        fin_q[$];
  logic [15:0] txd_q[$];
  cmd_t        mc;
  fin_t        mf;
  logic [15:0] mw;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   fcyc;
  logic host_req_prev = 1'b0;
  logic fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_cmd(input int c, input logic rwn, input logic [31:0] ahi, input logic [31:0] alo);
    cmd_q.push_back('{c, rwn, ahi, alo});
  endtask

  task automatic push_fin(input int c, input logic [127:0] d);
    fin_q.push_back('{c, d});
  endtask

  task automatic push_beats(input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) txd_q.push_back(b[i*16 +: 16]);
  endtask

  task automatic wait_host_req();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!host_req && n < 20);
    if (!host_req) begin
      checks++;
      errors++;
      $display("FAIL wait_host_req: got host_req=0, expected 1 within 20 cycles");
    end
  endtask

  // Drives the host side from bit masks indexed by cycle offset from host_req rising.
  task automatic run_host(input logic rd, input logic [31:0] ack_m, input logic [31:0] beat_m,
                          input logic [159:0] rx, input int ncyc, input logic stop_on_fin);
    int bi = 0;
    for (int t = 0; t < ncyc; t++) begin
      if (mem_finish) begin
        if (stop_on_fin) break;
        mem_request = 1'b0;
      end
      host_ack     = ack_m[t];
      host_txd_ack = !rd && beat_m[t];
      host_rxd_vld = rd && beat_m[t];
      host_rxd     = (rd && beat_m[t]) ? rx[bi*16 +: 16] : 16'h0;
      if (rd && beat_m[t]) bi++;
      tick();
    end
    host_ack = 1'b0; host_txd_ack = 1'b0; host_rxd_vld = 1'b0; host_rxd = 16'h0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_host_req"}, host_req, 1'b0);
    chk({tag, "_b0_host_req"}, b0_host_req, 1'b0);
    chk({tag, "_host_rwn"}, host_rwn, 1'b1);
    chk({tag, "_host_burst"}, host_burst, 1'b1);
    chk({tag, "_host_addr"}, host_addr, 32'h0);
    chk({tag, "_host_txm"}, host_txm, 2'b00);
    chk({tag, "_host_txd"}, host_txd, 16'h0);
    chk({tag, "_mem_finish"}, mem_finish, 1'b0);
    chk({tag, "_mem_read_data"}, mem_read_data, 128'h0);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_cmd_left"}, cmd_q.size(), 0);
    chk({tag, "_beat_left"}, txd_q.size(), 0);
    chk({tag, "_fin_left"}, fin_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (host_req && !host_req_prev) begin
        if (cmd_q.size() == 0) bad("cmd_unexpected");
        else begin
          mc = cmd_q.pop_front();
          $display("cmd  cyc=%0d rwn=%0b addr=%h", cyc, host_rwn, host_addr);
          chk("cmd_cycle", cyc, mc.cyc);
          chk("host_rwn", host_rwn, mc.rwn);
          chk("b0_host_rwn", b0_host_rwn, mc.rwn);
          chk("host_addr", host_addr, mc.a_hi);
          chk("b0_host_addr", b0_host_addr, mc.a_lo);
          chk("host_burst", host_burst & b0_host_burst, 1'b1);
          chk("host_txm", host_txm | b0_host_txm, 2'b00);
        end
      end
      if (host_txd_ack) begin
        if (txd_q.size() == 0) bad("txd_ack_unexpected");
        else begin
          mw = txd_q.pop_front();
          $display("beat cyc=%0d txd=%h", cyc, host_txd);
          chk("host_txd", host_txd, mw);
          chk("b0_host_txd", b0_host_txd, mw);
        end
      end
      if (mem_finish) begin
        chk("fin_consecutive", fin_prev, 1'b0);
        if (fin_q.size() == 0) bad("mem_finish_unexpected");
        else begin
          mf = fin_q.pop_front();
          $display("fin  cyc=%0d data=%h", cyc, mem_read_data);
          chk("fin_cycle", cyc, mf.cyc);
          chk("mem_read_data", mem_read_data, mf.data);
          chk("b0_mem_read_data", b0_mem_read_data, mf.data);
          chk("b0_mem_finish", b0_mem_finish, 1'b1);
        end
      end
    end
    host_req_prev <= host_req;
    fin_prev      <= mem_finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_request = 1'b0; mem_rwn = 1'b1; mem_addr = 16'h0; mem_write_data = '0;
    host_ack = 1'b0; host_txd_ack = 1'b0; host_rxd = 16'h0; host_rxd_vld = 1'b0;
    idle(3);
    check_reset("por");
    rst = 1'b0;
    idle(3);

    // 1: write line, ack 2 cycles after host_req, txd_ack every cycle
    mem_rwn = 1'b0; mem_addr = 16'h1234;
    mem_write_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b0, 32'h8000_1230, 32'h0000_1230);
    push_beats(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 8);
    wait_host_req();
    push_fin(cyc + 8, 128'h0);
    run_host(1'b0, 32'h4, 32'hFF, 160'h0, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t1");

    // 2: read line, gapped beats
    mem_rwn = 1'b1; mem_addr = 16'hFFF0; mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b1, 32'h8000_FFF0, 32'h0000_FFF0);
    wait_host_req();
    push_fin(cyc + 15, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    run_host(1'b1, 32'h2, 32'h5555, 160'h0000_0000_8888_7777_6666_5555_4444_3333_2222_1111, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t2");

    // 3: all beats before ack, 8th beat together with ack
    mem_rwn = 1'b1; mem_addr = 16'h0020; mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b1, 32'h8000_0020, 32'h0000_0020);
    wait_host_req();
    push_fin(cyc + 8, 128'hA008_A007_A006_A005_A004_A003_A002_A001);
    run_host(1'b1, 32'h80, 32'hFF, 160'h0000_0000_A008_A007_A006_A005_A004_A003_A002_A001, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t3");

    // 4: 9th and 10th beats arrive before a late ack and must be ignored
    mem_rwn = 1'b1; mem_addr = 16'h0A5F; mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b1, 32'h8000_0A50, 32'h0000_0A50);
    wait_host_req();
    push_fin(cyc + 11, 128'hC008_C007_C006_C005_C004_C003_C002_C001);
    run_host(1'b1, 32'h400, 32'h3FF, 160'hBEEF_DEAD_C008_C007_C006_C005_C004_C003_C002_C001, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t4");

    // 5: reset after 3 write beats, then a fresh write restarting at beat 0
    mem_rwn = 1'b0; mem_addr = 16'h4447;
    mem_write_data = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b0, 32'h8000_4440, 32'h0000_4440);
    push_beats(128'h0000_0000_0000_0000_0000_1514_1312_1110, 3);
    wait_host_req();
    run_host(1'b0, 32'h0, 32'h7, 160'h0, 3, 1'b0);
    mem_request = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("midburst");
    idle(2);
    rst = 1'b0;
    idle(3);
    check_empty("t5a");

    mem_rwn = 1'b0; mem_addr = 16'h5558;
    mem_write_data = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
    mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b0, 32'h8000_5550, 32'h0000_5550);
    push_beats(128'h2F2E_2D2C_2B2A_2928_2726_2524_2322_2120, 8);
    wait_host_req();
    push_fin(cyc + 8, 128'h0);
    run_host(1'b0, 32'h1, 32'hFF, 160'h0, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t5b");

    // 6: back-to-back, request held high across FIN with a new address
    mem_rwn = 1'b1; mem_addr = 16'h0100; mem_request = 1'b1;
    push_cmd(cyc + 1, 1'b1, 32'h8000_0100, 32'h0000_0100);
    wait_host_req();
    push_fin(cyc + 8, 128'h6008_6007_6006_6005_6004_6003_6002_6001);
    run_host(1'b1, 32'h1, 32'hFF, 160'h0000_0000_6008_6007_6006_6005_6004_6003_6002_6001, 24, 1'b1);
    fcyc = cyc;
    mem_rwn = 1'b0; mem_addr = 16'h0203;
    mem_write_data = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
    push_cmd(fcyc + 2, 1'b0, 32'h8000_0200, 32'h0000_0200);
    push_beats(128'h3F3E_3D3C_3B3A_3938_3736_3534_3332_3130, 8);
    wait_host_req();
    push_fin(cyc + 8, 128'h6008_6007_6006_6005_6004_6003_6002_6001);
    run_host(1'b0, 32'h8, 32'hFF, 160'h0, 24, 1'b0);
    mem_request = 1'b0;
    idle(3);
    check_empty("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
